// File: rtl/mock_cpu_pkg.sv
// mock_cpu_pkg: shared issue-control state encoding and default sizing.
package mock_cpu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DRAINED} issue_state_t;
  localparam int DEF_NREQ = 4;
  localparam int DEF_CREDITS = 8;
  localparam int SRC_W = $clog2(DEF_NREQ);
  localparam int CREDIT_W = $clog2(DEF_CREDITS + 1);
endpackage

// File: rtl/pipe_issue_arbiter_rr_pick.sv
// rr_pick: cyclic priority picker, first set request at or after ptr.
module rr_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  int j;
  // scan from the farthest offset down so the nearest hit wins
  always_comb begin
    idx = ptr;
    any = 1'b0;
    j = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        idx = W'(j);
        any = 1'b1;
      end
    end
    gnt = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/pipe_issue_arbiter.sv
// pipe_issue_arbiter: credit-gated round-robin issue of requester FIFO words into the pipeline.
module pipe_issue_arbiter
  import mock_cpu_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int DSIZE = 32,
  parameter int CREDITS = DEF_CREDITS,
  localparam int SW = $clog2(NREQ),
  localparam int CW = $clog2(CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_empty,
  input  logic [NREQ*DSIZE-1:0] req_rdata,
  output logic [NREQ-1:0]       req_rinc,
  output logic                  issue_valid,
  output logic [DSIZE-1:0]      issue_data,
  output logic [SW-1:0]         issue_src,
  input  logic                  credit_ret,
  input  logic                  issue_en,
  input  logic                  drain_req,
  output logic                  drained,
  output logic [CW-1:0]         credits,
  output logic                  credit_err
);
  issue_state_t state, state_nx;
  logic [SW-1:0] rr_ptr, win;
  logic [NREQ-1:0] gnt;
  logic any, grant, full;
  rr_pick #(.N(NREQ)) u_pick (
    .req(~req_empty),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(win),
    .any(any)
  );
  assign full = credits == CW'(CREDITS);
  assign grant = state == RUN && credits != '0 && any;
  assign req_rinc = grant ? gnt : '0;
  assign drained = state == DRAINED;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = issue_en && !drain_req ? RUN : IDLE;
      RUN:     state_nx = drain_req ? DRAIN : !issue_en ? IDLE : RUN;
      DRAIN:   state_nx = full ? DRAINED : DRAIN;
      DRAINED: state_nx = !drain_req ? IDLE : DRAINED;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      credits <= CW'(CREDITS);
      credit_err <= 1'b0;
      rr_ptr <= '0;
      issue_valid <= 1'b0;
      issue_data <= '0;
      issue_src <= '0;
    end else begin
      state <= state_nx;
      issue_valid <= grant;
      if (grant) begin
        issue_data <= req_rdata[win*DSIZE +: DSIZE];
        issue_src <= win;
        rr_ptr <= win == SW'(NREQ - 1) ? '0 : win + 1'b1;
      end
      // a return with nothing outstanding saturates and flags the error
      if (grant && !credit_ret) credits <= credits - 1'b1;
      else if (credit_ret && !grant && !full) credits <= credits + 1'b1;
      else if (credit_ret && !grant) credit_err <= 1'b1;
    end
  end
endmodule
